// File: rtl/shift_pkg.sv
// shift_pkg: shared operation and output-register state encodings
package shift_pkg;
   typedef enum logic [1:0] {SLL = 2'b00, SRL = 2'b01, PASS = 2'b10, SRA = 2'b11} shift_op_t;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;
endpackage

// File: rtl/shifter_core.sv
// shifter_core: combinational shifter supporting SLL, SRL, SRA and PASS
module shifter_core
   import shift_pkg::*;
#(
   parameter int N   = 32,
   parameter int SHW = $clog2(N)
) (
   input  logic [N-1:0]   in,
   input  logic [SHW-1:0] shamt,
   input  logic [1:0]     op,
   output logic [N-1:0]   out
);
   // Kept out of the ternary so the arithmetic shift keeps its signedness
   logic signed [N-1:0] sra;
   assign sra = $signed(in) >>> shamt;
   always_comb begin
      out = op == SLL ? in << shamt :
            op == SRL ? in >> shamt :
            op == SRA ? sra : in;
   end
endmodule

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two-port round-robin arbiter sharing one shifter, with a one-entry output register
module shifter_arbiter
   import shift_pkg::*;
#(
   parameter int N   = 32,
   parameter int SHW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           a_valid,
   output logic           a_ready,
   input  logic [1:0]     a_op,
   input  logic [N-1:0]   a_in,
   input  logic [SHW-1:0] a_shamt,
   input  logic           b_valid,
   output logic           b_ready,
   input  logic [1:0]     b_op,
   input  logic [N-1:0]   b_in,
   input  logic [SHW-1:0] b_shamt,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_data,
   output logic           out_src
);
   out_state_t     state_q, state_d;
   logic           rr_q, rr_d, src_q, src_d;
   logic [N-1:0]   data_q, data_d, sh_in, sh_out;
   logic [SHW-1:0] sh_amt;
   logic [1:0]     sh_op;
   logic           can_accept, grant;
   assign can_accept = rst && (state_q == EMPTY || out_ready);
   assign a_ready    = can_accept && a_valid && (!b_valid || !rr_q);
   assign b_ready    = can_accept && b_valid && (!a_valid || rr_q);
   assign grant      = a_ready || b_ready;
   assign sh_in      = b_ready ? b_in : a_in;
   assign sh_amt     = b_ready ? b_shamt : a_shamt;
   assign sh_op      = b_ready ? b_op : a_op;
   shifter_core #(.N(N), .SHW(SHW)) u_core (.in(sh_in), .shamt(sh_amt), .op(sh_op), .out(sh_out));
   // The pointer moves to the port that lost, so a waiting requester wins next time
   always_comb begin
      state_d = grant ? FULL : out_ready ? EMPTY : state_q;
      rr_d    = grant ? a_ready : rr_q;
      data_d  = grant ? sh_out : data_q;
      src_d   = grant ? b_ready : src_q;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= EMPTY;
         rr_q    <= 1'b0;
         data_q  <= '0;
         src_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end
   assign out_valid = state_q == FULL;
   assign out_data  = data_q;
   assign out_src   = src_q;
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: vector table, hand sequences and scoreboarded random traffic
module tb_shifter_arbiter;
   logic        clk = 1'b0, rst = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b1;
   logic        a_ready, b_ready, out_valid, out_src;
   logic [1:0]  a_op = 2'b10, b_op = 2'b10;
   logic [31:0] a_in = '0, b_in = '0, out_data;
   logic [4:0]  a_shamt = '0, b_shamt = '0;
   int          checks = 0, errors = 0;

   shifter_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_in(a_in), .a_shamt(a_shamt),
      .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_in(b_in), .b_shamt(b_shamt),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
   );

   always #5 clk = ~clk;

   typedef struct {logic [1:0] op; logic [31:0] din; logic [4:0] sh; logic [31:0] exp;} vec_t;
   typedef struct {logic src; logic [31:0] data;} res_t;
   vec_t  tbl[12];
   res_t  q[$];
   logic  rr_m = 1'b0, hold_pend = 1'b0, held_src;
   logic [31:0] held_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] din, input logic [4:0] sh);
      logic [31:0] r;
      int s;
      s = int'(sh);
      r = din;
      for (int i = 0; i < 32; i++) begin
         case (op)
            2'b00: r[i] = (i >= s) ? din[i-s] : 1'b0;
            2'b01: r[i] = (i + s < 32) ? din[i+s] : 1'b0;
            2'b11: r[i] = (i + s < 32) ? din[i+s] : din[31];
            default: r[i] = din[i];
         endcase
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor sits on the falling edge, where inputs and handshakes are stable
   always @(negedge clk) begin
      res_t r;
      logic ea, eb;
      if (!rst) begin
         chk("ready_in_reset", {a_ready, b_ready}, 2'b00);
         rr_m = 1'b0;
         hold_pend = 1'b0;
         q.delete();
      end else begin
         ea = (!out_valid || out_ready) && a_valid && (!b_valid || !rr_m);
         eb = (!out_valid || out_ready) && b_valid && (!a_valid || rr_m);
         chk("grant", {a_ready, b_ready}, {ea, eb});
         if (hold_pend) chk("hold", {out_valid, out_src, out_data}, {1'b1, held_src, held_data});
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %h with no expected entry", out_data);
            end else begin
               r = q.pop_front();
               chk("result", {out_src, out_data}, {r.src, r.data});
            end
         end
         if (a_valid && a_ready) begin
            q.push_back('{1'b0, model(a_op, a_in, a_shamt)});
            rr_m = 1'b1;
         end else if (b_valid && b_ready) begin
            q.push_back('{1'b1, model(b_op, b_in, b_shamt)});
            rr_m = 1'b0;
         end
         hold_pend = out_valid && !out_ready;
         held_src  = out_src;
         held_data = out_data;
      end
   end

   initial begin
      logic [31:0] hd;
      tbl[0]  = '{2'b00, 32'h0000_00F1,  5'd4, 32'h0000_0F10};
      tbl[1]  = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
      tbl[2]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
      tbl[3]  = '{2'b10, 32'hDEAD_BEEF,  5'd7, 32'hDEAD_BEEF};
      tbl[4]  = '{2'b00, 32'h1234_5678,  5'd0, 32'h1234_5678};
      tbl[5]  = '{2'b01, 32'h1234_5678,  5'd0, 32'h1234_5678};
      tbl[6]  = '{2'b11, 32'h8765_4321,  5'd0, 32'h8765_4321};
      tbl[7]  = '{2'b11, 32'h7FFF_0000,  5'd8, 32'h007F_FF00};
      tbl[8]  = '{2'b11, 32'hF000_0000,  5'd4, 32'hFF00_0000};
      tbl[9]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
      tbl[10] = '{2'b01, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF};
      tbl[11] = '{2'b10, 32'h0000_0000, 5'd31, 32'h0000_0000};
      a_valid = 1'b1;
      b_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_state", {out_valid, a_ready, b_ready, out_src, out_data}, 36'h0);
      end
      rst = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) begin
            a_valid = 1'b1; a_op = tbl[i].op; a_in = tbl[i].din; a_shamt = tbl[i].sh;
         end else begin
            b_valid = 1'b1; b_op = tbl[i].op; b_in = tbl[i].din; b_shamt = tbl[i].sh;
         end
         step();
         a_valid = 1'b0;
         b_valid = 1'b0;
         chk($sformatf("vec%0d", i), {out_valid, out_src, out_data}, {1'b1, 1'(i % 2), tbl[i].exp});
      end
      step();
      chk("drained", {31'h0, out_valid}, 32'h0);
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      a_valid = 1'b1; a_op = 2'b10; a_in = 32'hAAAA_0000;
      b_valid = 1'b1; b_op = 2'b00; b_in = 32'h0000_5555; b_shamt = 5'd4;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("alt%0d", i), {out_valid, out_src, out_data},
             {1'b1, 1'(i % 2), (i % 2) ? 32'h0005_5550 : 32'hAAAA_0000});
      end
      out_ready = 1'b0;
      #1;
      chk("stall_ready", {a_ready, b_ready}, 2'b00);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("stall%0d", i), {out_valid, out_src, out_data, a_ready, b_ready},
             {1'b1, 1'b1, 32'h0005_5550, 2'b00});
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_ready", {a_ready, b_ready}, 2'b10);
      step();
      chk("pop_push", {out_valid, out_src, out_data}, {1'b1, 1'b0, 32'hAAAA_0000});
      a_valid = 1'b0;
      b_valid = 1'b0;
      step();
      chk("empty_again", {31'h0, out_valid}, 32'h0);
      out_ready = 1'b0;
      a_valid = 1'b1; a_op = 2'b01; a_in = 32'hF000_000F; a_shamt = 5'd4;
      step();
      a_valid = 1'b0;
      chk("full_before_reset", {31'h0, out_valid}, 32'h1);
      rst = 1'b0;
      step();
      chk("mid_reset", {out_valid, out_src, out_data}, 34'h0);
      rst = 1'b1;
      a_valid = 1'b1; a_op = 2'b11; a_in = 32'hF000_000F; a_shamt = 5'd4;
      #1;
      chk("accept_after_release", {a_ready, b_ready}, 2'b10);
      step();
      a_valid = 1'b0;
      chk("after_release", {out_valid, out_src, out_data}, {1'b1, 1'b0, 32'hFF00_0000});
      out_ready = 1'b1;
      step();
      hd = '0;
      for (int i = 0; i < 10000; i++) begin
         a_valid = 1'($urandom_range(0, 1)); a_op = 2'($urandom_range(0, 3));
         a_in = $urandom; a_shamt = 5'($urandom_range(0, 31));
         b_valid = 1'($urandom_range(0, 1)); b_op = 2'($urandom_range(0, 3));
         b_in = $urandom; b_shamt = 5'($urandom_range(0, 31));
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("queue_empty", 64'(q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/shifter_arbiter.md
SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001: Parameter N, default 32, datapath width; only N=32 is required to be supported.
REQ-002: Parameter SHW, default $clog2(N), shift-amount width.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-low.
REQ-005: a_valid  input  1  requester A has a request.
REQ-006: a_ready  output  1  requester A request accepted this cycle.
REQ-007: a_op  input  2  requester A operation: 00 SLL, 01 SRL, 11 SRA, 10 PASS.
REQ-008: a_in  input  N  requester A operand.
REQ-009: a_shamt  input  SHW  requester A shift amount, 0..N-1.
REQ-010: b_valid, b_ready, b_op, b_in, b_shamt  same widths and meanings as REQ-005..009 for requester B.
REQ-011: out_valid  output  1  result register holds a valid result.
REQ-012: out_ready  input  1  consumer accepts the result this cycle.
REQ-013: out_data  output  N  shift result.
REQ-014: out_src  output  1  result owner: 0=A, 1=B.

Function
REQ-015: A transfer occurs on a port when valid and ready are both 1 at a rising edge.
REQ-016: Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017: can_accept = (state==EMPTY) | out_ready; no request is accepted when can_accept=0.
REQ-018: At most one request is granted per cycle; a_ready and b_ready are never both 1.
REQ-019: Only one port valid and can_accept=1 -> that port is granted.
REQ-020: Both ports valid and can_accept=1 -> the port named by round-robin pointer rr is granted (rr=0 selects A).
REQ-021: After any grant, rr becomes the index of the port not granted; rr holds when no grant occurs.
REQ-022: Granted request -> out_data, out_src, out_valid=1 are registered on that edge; latency 1 cycle, throughput 1 result/cycle under out_ready=1.
REQ-023: SLL: in << shamt, zero fill; SRL: in >> shamt, zero fill; SRA: in >> shamt, fill with in[N-1]; PASS: in unchanged, shamt ignored.
REQ-024: shamt=0 -> out_data equals in for every op.
REQ-025: FULL and out_ready=1 with no grant -> EMPTY next cycle.
REQ-026: FULL and out_ready=0 -> out_data, out_src, out_valid hold unchanged; a_ready=b_ready=0.
REQ-027: FULL, out_ready=1, and a grant in the same cycle -> stays FULL with the new result (simultaneous pop and push).
REQ-028: A requester whose valid is held while not granted is granted within 2 accepting cycles (no starvation).
REQ-029: Ready outputs depend combinationally on valid inputs and out_ready; requesters SHALL NOT make valid depend on ready.
REQ-030: Operand, op and shamt are sampled only in the grant cycle; changes on a non-granted port have no effect.

Reset
REQ-031: rst=0 at a rising edge -> state=EMPTY, out_valid=0, out_data=0, out_src=0, rr=0.
REQ-032: While rst=0, a_ready=b_ready=0 and no request is accepted.
REQ-033: Reset mid-operation discards any held result; first accepting cycle after rst returns to 1 is the cycle after release.

Structure
REQ-034: Package shift_pkg holds typedef enum shift_op_t {SLL=2'b00, SRL=2'b01, PASS=2'b10, SRA=2'b11} and output-state enum {EMPTY, FULL}.
REQ-035: One combinational sub-module, shifter_core (inputs in, shamt, op; output out), performs all shifts; it is instantiated exactly once and shared.
REQ-036: Arbitration, round-robin pointer, and output register are in shifter_arbiter.

Verification
REQ-037: Reset: hold rst=0 for 3 cycles with a_valid=b_valid=1 -> out_valid=0, a_ready=b_ready=0 every cycle.
REQ-038: A only, a_op=SLL, a_in=32'h0000_00F1, a_shamt=4 -> one cycle later out_data=32'h0000_0F10, out_src=0.
REQ-039: B only, b_op=SRA, b_in=32'h8000_0000, b_shamt=31 -> out_data=32'hFFFF_FFFF; same with SRL -> 32'h0000_0001.
REQ-040: Both valid continuously, out_ready=1 -> grants alternate A,B,A,B from reset; out_src sequence 0,1,0,1.
REQ-041: out_ready=0 for 4 cycles while FULL and both valid -> result held stable, no ready asserted; on out_ready=1 -> pop and new grant in the same cycle.
REQ-042: Random ops/shamt 0..31 on both ports with random out_ready for 10k cycles -> every result matches a reference model, no drop or duplicate, per-port order preserved.
